// File: rtl/altera_tse_pcs_rx_decode_if.sv
// Byte stream from the RX sync stage into the PCS receive decoder, and the
// GMII-style receive stream plus autoneg status coming back out.
interface altera_tse_pcs_rx_decode_if;
    logic [7:0]  rx_data;
    logic        rx_ctrl;
    logic        rx_errdetect;
    logic        rx_disperr;
    logic        rx_sync;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [15:0] rx_config_reg;
    logic        rx_config_valid;
    logic        ability_match;
    logic        rx_idle;

    modport master (
        output rx_data, rx_ctrl, rx_errdetect, rx_disperr, rx_sync,
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
        input  rx_config_reg, rx_config_valid, ability_match, rx_idle
    );

    modport slave (
        input  rx_data, rx_ctrl, rx_errdetect, rx_disperr, rx_sync,
        output gmii_rxd, gmii_rx_dv, gmii_rx_er,
        output rx_config_reg, rx_config_valid, ability_match, rx_idle
    );
endinterface

// File: rtl/altera_tse_pcs_rx_decode.sv
// 1000BASE-X PCS receive decoder: classifies /C/ /I/ /S/ /T/ /R/ /V/ ordered sets,
// produces a registered GMII receive stream and tracks the received autoneg config word.
module altera_tse_pcs_rx_decode #(
    parameter int MATCH_COUNT = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    altera_tse_pcs_rx_decode_if.slave     bus
);

    localparam logic [2:0] HUNT   = 3'd0;
    localparam logic [2:0] K_SEEN = 3'd1;
    localparam logic [2:0] CFG_LO = 3'd2;
    localparam logic [2:0] CFG_HI = 3'd3;
    localparam logic [2:0] PACKET = 3'd4;

    localparam logic [7:0] K28_5    = 8'hBC;
    localparam logic [7:0] K_START  = 8'hFB;
    localparam logic [7:0] K_TERM   = 8'hFD;
    localparam logic [7:0] K_ERRPRP = 8'hFE;
    localparam logic [7:0] D_C1     = 8'hB5;
    localparam logic [7:0] D_C2     = 8'h42;
    localparam logic [7:0] D_I1     = 8'hC5;
    localparam logic [7:0] D_I2     = 8'h50;
    localparam logic [7:0] PREAMBLE = 8'h55;
    localparam logic [7:0] ERR_BYTE = 8'hFE;
    localparam logic [2:0] CNT_MAX  = 3'd7;

    logic [2:0]  state, state_nxt;
    logic [7:0]  cfg_lo, cfg_lo_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [15:0] cfg_word, cfg_word_nxt;
    logic [7:0]  rxd, rxd_nxt;
    logic        dv, dv_nxt;
    logic        er, er_nxt;
    logic        cfg_valid, cfg_valid_nxt;
    logic        match, match_nxt;
    logic        idle, idle_nxt;

    logic        bad;
    logic        is_k285;
    logic        is_start;
    logic        is_term;
    logic        is_errprop;
    logic        is_cfg2;
    logic        is_idle2;
    logic [15:0] new_word;

    assign bad        = bus.rx_errdetect | bus.rx_disperr;
    assign is_k285    = bus.rx_ctrl  & (bus.rx_data == K28_5);
    assign is_start   = bus.rx_ctrl  & (bus.rx_data == K_START);
    assign is_term    = bus.rx_ctrl  & (bus.rx_data == K_TERM);
    assign is_errprop = bus.rx_ctrl  & (bus.rx_data == K_ERRPRP);
    assign is_cfg2    = ~bus.rx_ctrl & ((bus.rx_data == D_C1) | (bus.rx_data == D_C2));
    assign is_idle2   = ~bus.rx_ctrl & ((bus.rx_data == D_I1) | (bus.rx_data == D_I2));
    assign new_word   = {bus.rx_data, cfg_lo};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt     = state;
        cfg_lo_nxt    = cfg_lo;
        cnt_nxt       = cnt;
        cfg_word_nxt  = cfg_word;
        idle_nxt      = idle;
        cfg_valid_nxt = 1'b0;
        rxd_nxt       = 8'h00;
        dv_nxt        = 1'b0;
        er_nxt        = 1'b0;

        if (!bus.rx_sync) begin
            // Losing alignment mid-frame must still flag the truncated frame once.
            state_nxt = HUNT;
            cnt_nxt   = 3'd0;
            idle_nxt  = 1'b0;
            if (state == PACKET) begin
                rxd_nxt = ERR_BYTE;
                dv_nxt  = 1'b1;
                er_nxt  = 1'b1;
            end
        end else begin
            case (state)
                HUNT: begin
                    if (!bad) begin
                        if (is_k285) begin
                            state_nxt = K_SEEN;
                        end else if (is_start) begin
                            state_nxt = PACKET;
                            rxd_nxt   = PREAMBLE;
                            dv_nxt    = 1'b1;
                            idle_nxt  = 1'b0;
                            cnt_nxt   = 3'd0;
                        end
                    end
                end

                K_SEEN: begin
                    state_nxt = HUNT;
                    if (!bad) begin
                        if (is_cfg2) begin
                            state_nxt = CFG_LO;
                        end else if (is_idle2) begin
                            idle_nxt = 1'b1;
                            cnt_nxt  = 3'd0;
                        end
                    end
                end

                CFG_LO: begin
                    if (bad) begin
                        state_nxt = HUNT;
                    end else begin
                        cfg_lo_nxt = bus.rx_data;
                        state_nxt  = CFG_HI;
                    end
                end

                CFG_HI: begin
                    state_nxt = HUNT;
                    if (!bad) begin
                        cfg_word_nxt  = new_word;
                        cfg_valid_nxt = 1'b1;
                        idle_nxt      = 1'b0;
                        // A zero count means no previous word to compare against.
                        if (cnt == 3'd0 || new_word != cfg_word)
                            cnt_nxt = 3'd1;
                        else if (cnt != CNT_MAX)
                            cnt_nxt = cnt + 3'd1;
                    end
                end

                PACKET: begin
                    if (bad || is_errprop) begin
                        rxd_nxt = ERR_BYTE;
                        dv_nxt  = 1'b1;
                        er_nxt  = 1'b1;
                    end else if (is_term) begin
                        state_nxt = HUNT;
                    end else if (is_k285) begin
                        state_nxt = K_SEEN;
                        rxd_nxt   = ERR_BYTE;
                        dv_nxt    = 1'b1;
                        er_nxt    = 1'b1;
                    end else if (bus.rx_ctrl) begin
                        // Unexpected K character inside a frame is reported as a code error.
                        rxd_nxt = ERR_BYTE;
                        dv_nxt  = 1'b1;
                        er_nxt  = 1'b1;
                    end else begin
                        rxd_nxt = bus.rx_data;
                        dv_nxt  = 1'b1;
                    end
                end

                default: state_nxt = HUNT;
            endcase
        end

        match_nxt = (cnt_nxt >= 3'(MATCH_COUNT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            cfg_lo    <= 8'h00;
            cnt       <= 3'd0;
            cfg_word  <= 16'h0000;
            rxd       <= 8'h00;
            dv        <= 1'b0;
            er        <= 1'b0;
            cfg_valid <= 1'b0;
            match     <= 1'b0;
            idle      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_nxt;
            cfg_lo    <= cfg_lo_nxt;
            cnt       <= cnt_nxt;
            cfg_word  <= cfg_word_nxt;
            rxd       <= rxd_nxt;
            dv        <= dv_nxt;
            er        <= er_nxt;
            cfg_valid <= cfg_valid_nxt;
            match     <= match_nxt;
            idle      <= idle_nxt;
        end
    end

    assign bus.gmii_rxd        = rxd;
    assign bus.gmii_rx_dv      = dv;
    assign bus.gmii_rx_er      = er;
    assign bus.rx_config_reg   = cfg_word;
    assign bus.rx_config_valid = cfg_valid;
    assign bus.ability_match   = match;
    assign bus.rx_idle         = idle;

endmodule
